// File: rtl/nes_palette_ram.sv
// nes_palette_ram
//   Writable NES PPU palette memory. After reset a loader copies the 32-entry
//   palette ROM into internal storage; afterwards a CPU register port
//   (PPUCTRL / PPUADDR / PPUDATA subset) writes and reads entries, and a render
//   port reads entries with one cycle of latency.
//
// Ports
//   clk, rst_n   system clock (posedge), asynchronous active-low reset
//   rom_addr     palette ROM address during load (holds 31 once loaded)
//   rom_data     palette ROM data, valid one cycle after rom_addr
//   busy         high while the loader runs; CPU writes are dropped
//   reg_sel      0=CTRL 1=ADDR 2=DATA 3=reserved
//   reg_we       one-cycle register write strobe
//   reg_re       one-cycle DATA read strobe
//   status_rd    one-cycle strobe clearing the ADDR write toggle ($2002 read)
//   reg_din      register write data
//   reg_dout     DATA read result, valid with reg_dvalid
//   reg_dvalid   one-cycle pulse one cycle after an accepted reg_re
//   rd_addr      render read index
//   rd_dout      render read data, one cycle after rd_addr
module nes_palette_ram #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned DW      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  input  logic [1:0] reg_sel,
  input  logic       reg_we,
  input  logic       reg_re,
  input  logic       status_rd,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  output logic       reg_dvalid,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_dout
);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [DW-1:0] RESET_VAL = DW'(6'h0F);
  localparam logic [5:0]    LOAD_LAST = 6'd32;

  state_t        state, state_nxt;
  logic [5:0]    cnt, cnt_nxt;
  logic          load_we;
  logic [4:0]    load_idx;

  logic [DW-1:0] mem [ENTRIES];
  logic          mem_we;
  logic [4:0]    mem_idx;
  logic [DW-1:0] mem_wdat;

  logic [13:0]   v, v_nxt, v_step;
  logic          w, w_nxt;
  logic          inc32, inc32_nxt;

  logic          run;
  logic          wr_ctrl, wr_addr, wr_data;
  logic          rd_req, in_pal;
  logic [7:0]    rd_val_nxt;

  logic          unused_rom_bits;
  assign unused_rom_bits = ^rom_data[7:DW];

  // Background-colour mirrors: 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.
  function automatic logic [4:0] phys(input logic [4:0] i);
    return (i[4] && (i[1:0] == 2'b00)) ? {1'b0, i[3:0]} : i;
  endfunction

  function automatic logic [7:0] pad(input logic [DW-1:0] d);
    return 8'(d);
  endfunction

  // cnt runs 0..32: it drives rom_addr (clamped at 31) and, one cycle
  // behind, the storage write index for the ROM byte that just arrived.
  assign rom_addr = cnt[5] ? 5'h1F : cnt[4:0];
  assign busy     = (state == S_LOAD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_we   = 1'b0;
    load_idx  = cnt[4:0] - 5'd1;
    case (state)
      S_LOAD: begin
        load_we = (cnt != 6'd0);
        if (cnt == LOAD_LAST) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    run     = (state == S_RUN);
    wr_ctrl = run && reg_we && (reg_sel == 2'd0);
    wr_addr = run && reg_we && (reg_sel == 2'd1);
    wr_data = run && reg_we && (reg_sel == 2'd2);
    // A simultaneous write takes priority; the read is discarded.
    rd_req  = reg_re && !reg_we && (reg_sel == 2'd2);
    in_pal  = (v[13:8] == 6'h3F);
    v_step  = inc32 ? 14'd32 : 14'd1;

    v_nxt     = v;
    w_nxt     = w;
    inc32_nxt = inc32;

    if (wr_ctrl) begin
      inc32_nxt = reg_din[2];
    end
    if (wr_addr) begin
      if (!w) begin
        v_nxt[13:8] = reg_din[5:0];
        w_nxt       = 1'b1;
      end else begin
        v_nxt[7:0]  = reg_din;
        w_nxt       = 1'b0;
      end
    end
    if (wr_data || (run && rd_req)) begin
      v_nxt = v + v_step;
    end
    // Applied after the ADDR write so a coincident $2002 read wins.
    if (run && status_rd) begin
      w_nxt = 1'b0;
    end

    rd_val_nxt = (run && in_pal) ? pad(mem[phys(v[4:0])]) : 8'h00;

    mem_we   = 1'b0;
    mem_idx  = phys(v[4:0]);
    mem_wdat = reg_din[DW-1:0];
    if (load_we) begin
      mem_we   = 1'b1;
      mem_idx  = phys(load_idx);
      mem_wdat = rom_data[DW-1:0];
    end else if (wr_data && in_pal) begin
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      cnt        <= '0;
      v          <= '0;
      w          <= 1'b0;
      inc32      <= 1'b0;
      reg_dout   <= '0;
      reg_dvalid <= 1'b0;
      rd_dout    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      v          <= v_nxt;
      w          <= w_nxt;
      inc32      <= inc32_nxt;
      reg_dvalid <= rd_req;
      if (rd_req) begin
        reg_dout <= rd_val_nxt;
      end
      // Reads the pre-write value when the same entry is written this cycle.
      rd_dout    <= pad(mem[phys(rd_addr)]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (mem_we) begin
      mem[mem_idx] <= mem_wdat;
    end
  end

endmodule
